// File: rtl/ram_access_ctrl_if.sv
// Command/response bundle between a requester and ram_access_ctrl.
//   cmd_*  : valid/ready command channel (write = 1 for writes, wdata ignored on reads)
//   rsp_*  : valid/ready read-response channel (rdata plus out-of-range error flag)
// master : the requester side; slave : ram_access_ctrl.
interface ram_access_ctrl_if #(
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned A_WIDTH = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [A_WIDTH-1:0] cmd_addr;
  logic [D_WIDTH-1:0] cmd_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [D_WIDTH-1:0] rsp_rdata;
  logic               rsp_err;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Single-clock initiator for a 1R/1W RAM with registered read data.
// After reset it clears every word to INIT_VALUE, then serves read/write commands from the
// bus interface. Read results return in order through a 2-entry response buffer; a credit rule
// on cmd_ready guarantees the buffer never overflows, so response backpressure is lossless.
// Ports:
//   clk, rst_n           clock (also the RAM clock) and async active-low reset
//   bus                  command/response interface (slave side)
//   init_done            high once the clear pass has finished
//   ram_address_write,
//   ram_data_write,
//   ram_write_enable     RAM write port
//   ram_address_read     RAM read address (holds last value when idle)
//   ram_data_read        RAM read data, one cycle after the address
module ram_access_ctrl #(
  parameter int unsigned         D_WIDTH    = 16,
  parameter int unsigned         A_WIDTH    = 4,
  parameter int unsigned         A_MAX      = 16,
  parameter logic [D_WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_access_ctrl_if.slave   bus,
  output logic               init_done,
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic               ram_write_enable,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read
);

  localparam logic [A_WIDTH:0]   AMaxW    = (A_WIDTH+1)'(A_MAX);
  localparam logic [A_WIDTH-1:0] LastAddr = A_WIDTH'(A_MAX - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic               rd_inflight_q;
  logic               rd_err_q;
  logic [A_WIDTH-1:0] rd_addr_q;
  logic [D_WIDTH-1:0] fifo_data_q [2];
  logic               fifo_err_q  [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q, count_d;

  logic               pop, push;
  logic [2:0]         credit_used;
  logic               in_range;
  logic               cmd_ready_c, accept, rd_accept;
  logic               we_c;
  logic [A_WIDTH-1:0] waddr_c;
  logic [D_WIDTH-1:0] wdata_c;
  logic [D_WIDTH-1:0] push_data;

  assign pop      = bus.rsp_valid & bus.rsp_ready;
  assign push     = rd_inflight_q;
  // Out-of-range reads never touched the RAM, so their slot carries zero data.
  assign push_data = rd_err_q ? '0 : ram_data_read;
  assign in_range = {1'b0, bus.cmd_addr} < AMaxW;
  // Slots already promised: buffered responses plus the read in flight, minus one leaving now.
  assign credit_used = {1'b0, count_q} + {2'b00, rd_inflight_q} - {2'b00, pop};

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    cmd_ready_c = 1'b0;
    accept      = 1'b0;
    rd_accept   = 1'b0;
    we_c        = 1'b0;
    waddr_c     = '0;
    wdata_c     = '0;
    case (state_q)
      StInit: begin
        we_c       = 1'b1;
        waddr_c    = init_cnt_q;
        wdata_c    = INIT_VALUE;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LastAddr) state_d = StRun;
      end
      StRun: begin
        cmd_ready_c = credit_used < 3'd2;
        accept      = bus.cmd_valid & cmd_ready_c;
        rd_accept   = accept & ~bus.cmd_write;
        if (accept & bus.cmd_write & in_range) begin
          we_c    = 1'b1;
          waddr_c = bus.cmd_addr;
          wdata_c = bus.cmd_wdata;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + 2'd1;
    if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StInit;
      init_cnt_q    <= '0;
      rd_inflight_q <= 1'b0;
      rd_err_q      <= 1'b0;
      rd_addr_q     <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      rd_inflight_q <= rd_accept;
      rd_err_q      <= rd_accept & ~in_range;
      if (rd_accept && in_range) rd_addr_q <= bus.cmd_addr;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_err_q[wr_ptr_q]  <= rd_err_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.rsp_valid = count_q != 2'd0;
  assign bus.rsp_rdata = fifo_data_q[rd_ptr_q];
  assign bus.rsp_err   = fifo_err_q[rd_ptr_q];
  assign init_done     = state_q == StRun;

  // The write port is forced quiet while reset is held, even though the FSM sits in StInit.
  assign ram_write_enable  = we_c & rst_n;
  assign ram_address_write = rst_n ? waddr_c : '0;
  assign ram_data_write    = rst_n ? wdata_c : '0;
  assign ram_address_read  = (rd_accept && in_range) ? bus.cmd_addr : rd_addr_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Two controllers (A_MAX=32 and A_MAX=24) share one stimulus stream; each has its own RAM and
// its own reference model (expected memory image plus a list of pending read responses).
module tb_ram_access_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_next = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;

  ram_access_ctrl_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus_a ();
  ram_access_ctrl_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus_b ();

  assign bus_a.cmd_valid = cmd_valid;
  assign bus_a.cmd_write = cmd_write;
  assign bus_a.cmd_addr  = cmd_addr;
  assign bus_a.cmd_wdata = cmd_wdata;
  assign bus_a.rsp_ready = rsp_ready;
  assign bus_b.cmd_valid = cmd_valid;
  assign bus_b.cmd_write = cmd_write;
  assign bus_b.cmd_addr  = cmd_addr;
  assign bus_b.cmd_wdata = cmd_wdata;
  assign bus_b.rsp_ready = rsp_ready;

  logic          o_ready [2], o_valid [2], o_err [2], o_done [2], o_we [2];
  logic [DW-1:0] o_rdata [2], o_wdata [2], o_dr [2];
  logic [AW-1:0] o_waddr [2], o_raddr [2];

  assign o_ready[0] = bus_a.cmd_ready;
  assign o_valid[0] = bus_a.rsp_valid;
  assign o_rdata[0] = bus_a.rsp_rdata;
  assign o_err[0]   = bus_a.rsp_err;
  assign o_ready[1] = bus_b.cmd_ready;
  assign o_valid[1] = bus_b.rsp_valid;
  assign o_rdata[1] = bus_b.rsp_rdata;
  assign o_err[1]   = bus_b.rsp_err;

  ram_access_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(32), .INIT_VALUE(8'h00)) u_dut_a (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus_a),
    .init_done         (o_done[0]),
    .ram_address_write (o_waddr[0]),
    .ram_data_write    (o_wdata[0]),
    .ram_write_enable  (o_we[0]),
    .ram_address_read  (o_raddr[0]),
    .ram_data_read     (o_dr[0])
  );

  ram_access_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(24), .INIT_VALUE(8'h00)) u_dut_b (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus_b),
    .init_done         (o_done[1]),
    .ram_address_write (o_waddr[1]),
    .ram_data_write    (o_wdata[1]),
    .ram_write_enable  (o_we[1]),
    .ram_address_read  (o_raddr[1]),
    .ram_data_read     (o_dr[1])
  );

  // Attached RAMs: synchronous write, registered read.
  logic [DW-1:0] ram_a [32];
  logic [DW-1:0] ram_b [32];
  always_ff @(posedge clk) begin
    if (o_we[0]) ram_a[o_waddr[0]] <= o_wdata[0];
    o_dr[0] <= ram_a[o_raddr[0]];
    if (o_we[1]) ram_b[o_waddr[1]] <= o_wdata[1];
    o_dr[1] <= ram_b[o_raddr[1]];
  end

  // Reference model state, one set per controller.
  logic [DW-1:0] exp_mem [2][32];
  int            k [2];
  logic          rq_err [2][64];
  logic [DW-1:0] rq_dat [2][64];
  int            rq_acc [2][64];
  int            head [2], tail [2];
  int            cyc = 0;
  int            n_total = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int amax_of(input int i);
    return (i == 0) ? 32 : 24;
  endfunction

  task automatic step_model(input int i);
    int   amax;
    bit   run, exp_valid, pop, exp_ready, accept, exp_we, in_rng;
    int   hs;
    amax = amax_of(i);
    if (!rst_n) begin
      check_eq($sformatf("d%0d rst cmd_ready", i), 32'(o_ready[i]), 0);
      check_eq($sformatf("d%0d rst rsp_valid", i), 32'(o_valid[i]), 0);
      check_eq($sformatf("d%0d rst rsp_rdata", i), 32'(o_rdata[i]), 0);
      check_eq($sformatf("d%0d rst rsp_err", i), 32'(o_err[i]), 0);
      check_eq($sformatf("d%0d rst init_done", i), 32'(o_done[i]), 0);
      check_eq($sformatf("d%0d rst we", i), 32'(o_we[i]), 0);
      k[i] = 0;
      head[i] = 0;
      tail[i] = 0;
      for (int a = 0; a < 32; a++) exp_mem[i][a] = 8'h00;
      return;
    end
    run       = k[i] >= amax;
    hs        = head[i] % 64;
    exp_valid = (tail[i] > head[i]) && (rq_acc[i][hs] + 2 <= cyc);
    pop       = exp_valid && rsp_ready;
    exp_ready = run && ((tail[i] - head[i] - int'(pop)) < 2);
    accept    = cmd_valid && exp_ready;
    in_rng    = int'(cmd_addr) < amax;
    exp_we    = run ? (accept && cmd_write && in_rng) : 1'b1;

    check_eq($sformatf("d%0d init_done", i), 32'(o_done[i]), 32'(run));
    check_eq($sformatf("d%0d cmd_ready", i), 32'(o_ready[i]), 32'(exp_ready));
    check_eq($sformatf("d%0d rsp_valid", i), 32'(o_valid[i]), 32'(exp_valid));
    check_eq($sformatf("d%0d ram_we", i), 32'(o_we[i]), 32'(exp_we));
    if (exp_we) begin
      check_eq($sformatf("d%0d ram_waddr", i), 32'(o_waddr[i]),
               run ? 32'(cmd_addr) : 32'(k[i]));
      check_eq($sformatf("d%0d ram_wdata", i), 32'(o_wdata[i]), run ? 32'(cmd_wdata) : 0);
    end
    if (exp_valid) begin
      check_eq($sformatf("d%0d rsp_rdata", i), 32'(o_rdata[i]), 32'(rq_dat[i][hs]));
      check_eq($sformatf("d%0d rsp_err", i), 32'(o_err[i]), 32'(rq_err[i][hs]));
    end
    if (accept && !cmd_write && in_rng)
      check_eq($sformatf("d%0d ram_raddr", i), 32'(o_raddr[i]), 32'(cmd_addr));

    if (pop) head[i]++;
    if (accept) begin
      if (cmd_write) begin
        if (in_rng) exp_mem[i][cmd_addr] = cmd_wdata;
      end else begin
        rq_err[i][tail[i] % 64] = !in_rng;
        rq_dat[i][tail[i] % 64] = in_rng ? exp_mem[i][cmd_addr] : 8'h00;
        rq_acc[i][tail[i] % 64] = cyc;
        tail[i]++;
      end
    end
    if (!run) k[i]++;
  endtask

  task automatic cycle(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr);
    @(negedge clk);
    rst_n     = rst_next;
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    rsp_ready = rr;
    #4;
    for (int i = 0; i < 2; i++) step_model(i);
    cyc++;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int j = 0; j < n; j++) cycle(1'b0, 1'b0, '0, '0, rr);
  endtask

  initial begin
    // Reset, release, clear pass, then a read of a cleared word.
    rst_next = 1'b0;
    idle(3, 1'b1);
    rst_next = 1'b1;
    idle(33, 1'b1);
    cycle(1'b1, 1'b0, 5'h1B, 8'h00, 1'b1);
    idle(3, 1'b1);

    // Write then read the same address on the next cycle.
    cycle(1'b1, 1'b1, 5'h1B, 8'hC5, 1'b1);
    cycle(1'b1, 1'b0, 5'h1B, 8'h00, 1'b1);
    idle(3, 1'b1);

    // Preload 0..7, then back-to-back reads with the response side always ready.
    for (int j = 0; j < 8; j++) cycle(1'b1, 1'b1, 5'(j), 8'(8'h10 + j), 1'b1);
    for (int j = 0; j < 8; j++) cycle(1'b1, 1'b0, 5'(j), 8'h00, 1'b1);
    idle(3, 1'b1);

    // Response backpressure: reads offered every cycle while rsp_ready is low.
    for (int j = 0; j < 6; j++) cycle(1'b1, 1'b0, 5'(j + 2), 8'h00, 1'b0);
    for (int j = 0; j < 4; j++) cycle(1'b1, 1'b0, 5'(j + 4), 8'h00, 1'b1);
    idle(3, 1'b1);

    // Addresses beyond the 24-word controller.
    cycle(1'b1, 1'b1, 5'h1C, 8'hAA, 1'b1);
    cycle(1'b1, 1'b0, 5'h1C, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 5'h17, 8'h00, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic.
    for (int j = 0; j < 3000; j++)
      cycle($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), 8'($urandom),
            $urandom_range(0, 3) != 0);
    idle(4, 1'b1);

    // Reset with responses buffered, then the clear pass must rerun.
    for (int j = 0; j < 4; j++) cycle(1'b1, 1'b0, 5'h1B, 8'h00, 1'b0);
    rst_next = 1'b0;
    idle(3, 1'b1);
    rst_next = 1'b1;
    idle(33, 1'b1);
    cycle(1'b1, 1'b0, 5'h1B, 8'h00, 1'b1);
    idle(4, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
